branch_seq_ctrl: RTL and testbench

//  Fetch sequencer and branch scheduler for the 5-stage pipeline. Owns the PC, the NZCV flags register
//  and the per-cycle redirect/flush/stall decisions. Resolves conditional branches in EX with forwarded

---
 rtl/pipe_pkg.sv | 40 ++++
 rtl/cond_eval.sv | 42 ++++
 rtl/branch_seq_ctrl.sv | 140 ++++++++++++++
 tb/tb_branch_seq_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: NZCV bit positions, branch condition codes,
// sequencer state encoding and instruction size.
package pipe_pkg;

  // Bit positions inside a {N,Z,C,V} flags vector.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // 4-bit branch condition codes.
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  // Fetch sequencer states.
  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

  // Every instruction occupies one 32-bit word.
  localparam int unsigned INST_BYTES = 4;

endpackage

// File: rtl/cond_eval.sv
// Branch condition evaluator: decides whether a condition code passes for a
// given {N,Z,C,V} flags vector. Purely combinational.
module cond_eval
  import pipe_pkg::*;
(
  input  logic [3:0] i_cond,
  input  logic [3:0] i_flags,
  output logic       o_pass
);

  logic w_n, w_z, w_c, w_v;

  assign w_n = i_flags[FLAG_N];
  assign w_z = i_flags[FLAG_Z];
  assign w_c = i_flags[FLAG_C];
  assign w_v = i_flags[FLAG_V];

  // Map each condition code onto the flag predicate it names.
  always_comb begin
    // NOTE: assign a default before the case so no path leaves o_pass unassigned (no latch).
    o_pass = 1'b0;
    case (i_cond)
      COND_EQ: o_pass = w_z;
      COND_NE: o_pass = ~w_z;
      COND_CS: o_pass = w_c;
      COND_CC: o_pass = ~w_c;
      COND_MI: o_pass = w_n;
      COND_PL: o_pass = ~w_n;
      COND_VS: o_pass = w_v;
      COND_VC: o_pass = ~w_v;
      COND_HI: o_pass = w_c & ~w_z;
      COND_LS: o_pass = ~w_c | w_z;
      COND_GE: o_pass = (w_n == w_v);
      COND_LT: o_pass = (w_n != w_v);
      COND_GT: o_pass = ~w_z & (w_n == w_v);
      COND_LE: o_pass = w_z | (w_n != w_v);
      COND_AL: o_pass = 1'b1;
      COND_NV: o_pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_seq_ctrl.sv
// Fetch sequencer and branch scheduler for the 5-stage pipeline. Owns the PC,
// the NZCV flags register and the per-cycle redirect/flush/stall decisions,
// resolves EX-stage branches with forwarded flags and drains the pipe on HALT.
module branch_seq_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned     PC_W      = 32,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter int unsigned     DRAIN_CYC = 3,
  parameter int unsigned     CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall_req,
  input  logic             imem_ready,
  input  logic             ex_branch,
  input  logic [3:0]       ex_cond,
  input  logic [PC_W-1:0]  ex_target,
  input  logic             ex_halt,
  input  logic             mem_setflags,
  input  logic [3:0]       mem_flags,
  input  logic             resume,
  output logic [PC_W-1:0]  pc,
  output logic             fetch_valid,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic [3:0]       flags,
  output logic             branch_taken,
  output logic             halted,
  output logic [CNT_W-1:0] taken_cnt
);

  // Drain counter holds DRAIN_CYC-1 down to 0.
  localparam int unsigned DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  state_t           r_state, w_state_nxt;
  logic [PC_W-1:0]  r_pc, w_pc_nxt;
  logic [3:0]       r_flags;
  logic [CNT_W-1:0] r_taken_cnt;
  logic [DW-1:0]    r_drain_cnt, w_drain_nxt;
  logic [3:0]       w_eval_flags;
  logic             w_cond_pass;
  logic             w_taken;

  // A flag-setting instruction in MEM is younger than the flags register, so
  // its result is forwarded to the branch resolving in EX this cycle.
  assign w_eval_flags = mem_setflags ? mem_flags : r_flags;

  cond_eval u_cond_eval (
    .i_cond  (ex_cond),
    .i_flags (w_eval_flags),
    .o_pass  (w_cond_pass)
  );

  assign w_taken      = ex_branch & w_cond_pass & (r_state == ST_RUN);
  assign branch_taken = w_taken;
  assign pc           = r_pc;
  assign flags        = r_flags;
  assign taken_cnt    = r_taken_cnt;

  // Next-state, next-PC and per-cycle pipeline control decisions.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_drain_nxt = r_drain_cnt;
    fetch_valid = 1'b0;
    if_id_en    = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    halted      = 1'b0;
    case (r_state)
      ST_BOOT: begin
        w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        fetch_valid = 1'b1;
        if (w_taken) begin
          // Redirect wins over everything, killing the two younger slots.
          w_pc_nxt    = ex_target;
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (ex_halt) begin
          // Stop fetching; pc keeps HALT+4 for the eventual resume.
          fetch_valid = 1'b0;
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          w_drain_nxt = DW'(DRAIN_CYC - 1);
          w_state_nxt = ST_DRAIN;
        end else if (stall_req) begin
          id_ex_flush = 1'b1;
        end else if (!imem_ready) begin
          if_id_flush = 1'b1;
        end else begin
          w_pc_nxt = r_pc + PC_W'(INST_BYTES);
          if_id_en = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (r_drain_cnt == '0) begin
          w_state_nxt = ST_HALTED;
        end else begin
          w_drain_nxt = r_drain_cnt - 1'b1;
        end
      end
      ST_HALTED: begin
        halted = 1'b1;
        if (resume) begin
          w_state_nxt = ST_RUN;
        end
      end
      default: begin
        w_state_nxt = ST_BOOT;
      end
    endcase
  end

  // State, PC, drain counter, flags register and saturating taken counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_BOOT;
      r_pc        <= RESET_PC;
      r_drain_cnt <= '0;
      r_flags     <= '0;
      r_taken_cnt <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_drain_cnt <= w_drain_nxt;
      if (mem_setflags && (r_state != ST_BOOT)) begin
        r_flags <= mem_flags;
      end
      if (w_taken && (r_taken_cnt != '1)) begin
        r_taken_cnt <= r_taken_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_branch_seq_ctrl.sv
// Self-checking bench for branch_seq_ctrl: directed stimulus, a behavioural
// model compared on every cycle, and literal expectations at key points.
module tb_branch_seq_ctrl;

  localparam int DRAIN = 3;

  logic        clk;
  logic        reset;
  logic        stall_req, imem_ready, ex_branch, ex_halt, mem_setflags, resume;
  logic [3:0]  ex_cond, mem_flags;
  logic [31:0] ex_target;
  logic [31:0] pc;
  logic        fetch_valid, if_id_en, if_id_flush, id_ex_flush, branch_taken, halted;
  logic [3:0]  flags;
  logic [15:0] taken_cnt;

  int n_vec = 0;
  int n_err = 0;

  branch_seq_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .stall_req    (stall_req),
    .imem_ready   (imem_ready),
    .ex_branch    (ex_branch),
    .ex_cond      (ex_cond),
    .ex_target    (ex_target),
    .ex_halt      (ex_halt),
    .mem_setflags (mem_setflags),
    .mem_flags    (mem_flags),
    .resume       (resume),
    .pc           (pc),
    .fetch_valid  (fetch_valid),
    .if_id_en     (if_id_en),
    .if_id_flush  (if_id_flush),
    .id_ex_flush  (id_ex_flush),
    .flags        (flags),
    .branch_taken (branch_taken),
    .halted       (halted),
    .taken_cnt    (taken_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_pc;
  logic [3:0]  m_flags;
  int          m_cnt;
  bit          m_boot;
  int          m_drain_left;
  bit          m_halted;

  function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      4'd0:    return z;
      4'd1:    return !z;
      4'd2:    return cy;
      4'd3:    return !cy;
      4'd4:    return n;
      4'd5:    return !n;
      4'd6:    return v;
      4'd7:    return !v;
      4'd8:    return cy && !z;
      4'd9:    return !cy || z;
      4'd10:   return n == v;
      4'd11:   return n != v;
      4'd12:   return !z && (n == v);
      4'd13:   return z || (n != v);
      4'd14:   return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    m_pc = 32'h0; m_flags = 4'h0; m_cnt = 0;
    m_boot = 1'b1; m_drain_left = 0; m_halted = 1'b0;
  endtask

  bit         c_run, c_tk;
  logic [3:0] c_ef;

  // Compare process: evaluate mid-cycle, then advance the model at the edge.
  initial begin : compare
    model_reset();
    forever begin
      @(negedge clk);
      #2;
      if (reset) model_reset();
      c_run = !reset && !m_boot && (m_drain_left == 0) && !m_halted;
      c_ef  = mem_setflags ? mem_flags : m_flags;
      c_tk  = c_run && ex_branch && cond_ok(ex_cond, c_ef);
      check("pc",           pc,           m_pc);
      check("flags",        flags,        m_flags);
      check("taken_cnt",    taken_cnt,    m_cnt);
      check("branch_taken", branch_taken, c_tk);
      check("fetch_valid",  fetch_valid,  c_run && (c_tk || !ex_halt));
      check("if_id_en",     if_id_en,     c_run && !c_tk && !ex_halt && !stall_req && imem_ready);
      check("if_id_flush",  if_id_flush,  c_run && (c_tk || ex_halt || (!stall_req && !imem_ready)));
      check("id_ex_flush",  id_ex_flush,  c_run && (c_tk || ex_halt || stall_req));
      check("halted",       halted,       !reset && m_halted);
      @(posedge clk);
      if (!reset) begin
        if (!m_boot && mem_setflags) m_flags = mem_flags;
        if (m_boot) begin
          m_boot = 1'b0;
        end else if (c_run) begin
          if (c_tk) begin
            m_pc = ex_target;
            if (m_cnt < 65535) m_cnt++;
          end else if (ex_halt) begin
            m_drain_left = DRAIN;
          end else if (!stall_req && imem_ready) begin
            m_pc = m_pc + 32'd4;
          end
        end else if (m_drain_left > 0) begin
          m_drain_left--;
          if (m_drain_left == 0) m_halted = 1'b1;
        end else if (m_halted && resume) begin
          m_halted = 1'b0;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_idle();
    stall_req = 0; imem_ready = 1; ex_branch = 0; ex_cond = 4'hF;
    ex_target = 32'h0; ex_halt = 0; mem_setflags = 0; mem_flags = 4'h0; resume = 0;
  endtask

  // Move to the next cycle's drive point with idle inputs.
  task automatic next_cycle();
    @(negedge clk);
    set_idle();
  endtask

  initial begin : stim
    reset = 1'b1;
    set_idle();
    next_cycle();
    next_cycle();
    // 1: boot cycle then sequential fetch
    reset = 1'b0; #3;
    check("t1_boot_fv", fetch_valid, 1'b0);
    check("t1_boot_pc", pc, 32'h0);
    next_cycle(); #3;
    check("t1_fv", fetch_valid, 1'b1);
    check("t1_pc0", pc, 32'h0);
    next_cycle(); #3; check("t1_pc4", pc, 32'h4);
    next_cycle(); #3; check("t1_pc8", pc, 32'h8);
    next_cycle(); #3; check("t1_pc12", pc, 32'hC);
    // 2: flags register Z=1, EQ branch taken
    next_cycle(); mem_setflags = 1; mem_flags = 4'b0100; #3;
    next_cycle(); ex_branch = 1; ex_cond = 4'h0; ex_target = 32'h100; #3;
    check("t2_flags", flags, 4'b0100);
    check("t2_taken", branch_taken, 1'b1);
    check("t2_ifid_flush", if_id_flush, 1'b1);
    check("t2_idex_flush", id_ex_flush, 1'b1);
    // 3: clear flags, then forwarded Z for EQ (taken) and NE (not taken)
    next_cycle(); mem_setflags = 1; mem_flags = 4'b0000; #3;
    check("t2_pc", pc, 32'h100);
    check("t2_cnt", taken_cnt, 16'd1);
    next_cycle(); mem_setflags = 1; mem_flags = 4'b0100;
    ex_branch = 1; ex_cond = 4'h0; ex_target = 32'h200; #3;
    check("t3_flags_clear", flags, 4'b0000);
    check("t3_fwd_eq", branch_taken, 1'b1);
    next_cycle(); mem_setflags = 1; mem_flags = 4'b0100;
    ex_branch = 1; ex_cond = 4'h1; ex_target = 32'h900; #3;
    check("t3_pc", pc, 32'h200);
    check("t3_fwd_ne", branch_taken, 1'b0);
    // 4: stall + taken branch, then stall alone, then imem not ready
    next_cycle(); stall_req = 1; ex_branch = 1; ex_cond = 4'hE; ex_target = 32'h300; #3;
    check("t3_pc_inc", pc, 32'h204);
    check("t4_br_over_stall", branch_taken, 1'b1);
    next_cycle(); stall_req = 1; #3;
    check("t4_pc_target", pc, 32'h300);
    check("t4_stall_en", if_id_en, 1'b0);
    check("t4_stall_idex", id_ex_flush, 1'b1);
    next_cycle(); imem_ready = 0; #3;
    check("t4_pc_held", pc, 32'h300);
    check("t4_nrdy_flush", if_id_flush, 1'b1);
    // 5: branch to 0x20, HALT there, drain, halted, resume
    next_cycle(); ex_branch = 1; ex_cond = 4'hE; ex_target = 32'h20; #3;
    next_cycle(); ex_halt = 1; #3;
    check("t5_halt_pc", pc, 32'h20);
    check("t5_halt_fv", fetch_valid, 1'b0);
    for (int i = 0; i < DRAIN; i++) begin
      next_cycle(); ex_branch = 1; ex_cond = 4'hE; ex_target = 32'h500;
      stall_req = 1; ex_halt = 1; #3;
      check("t5_drain_fv", fetch_valid, 1'b0);
      check("t5_drain_br", branch_taken, 1'b0);
      check("t5_drain_halted", halted, 1'b0);
    end
    next_cycle(); #3;
    check("t5_halted", halted, 1'b1);
    next_cycle(); resume = 1; #3;
    check("t5_halted_resume", halted, 1'b1);
    next_cycle(); #3;
    check("t5_resumed", halted, 1'b0);
    check("t5_resume_fv", fetch_valid, 1'b1);
    check("t5_resume_pc", pc, 32'h20);
    // 6: saturate taken counter (4 taken so far)
    for (int i = 0; i < 65531; i++) begin
      next_cycle(); ex_branch = 1; ex_cond = 4'hE; ex_target = 32'h40; #3;
    end
    next_cycle(); ex_branch = 1; ex_cond = 4'hE; ex_target = 32'h40; #3;
    check("t6_cnt_max", taken_cnt, 16'hFFFF);
    next_cycle(); ex_branch = 1; ex_cond = 4'hE; ex_target = 32'hFFFF_FFFC; #3;
    check("t6_cnt_sat", taken_cnt, 16'hFFFF);
    next_cycle(); #3;
    check("t6_pc_top", pc, 32'hFFFF_FFFC);
    next_cycle(); #3;
    check("t6_pc_wrap", pc, 32'h0);
    next_cycle(); ex_halt = 1; #3;
    check("t6_halt_pc", pc, 32'h4);
    next_cycle(); #3;
    next_cycle(); reset = 1'b1; #3;
    check("t6_rst_pc", pc, 32'h0);
    check("t6_rst_flags", flags, 4'h0);
    check("t6_rst_cnt", taken_cnt, 16'h0);
    check("t6_rst_fv", fetch_valid, 1'b0);
    check("t6_rst_halted", halted, 1'b0);
    next_cycle(); reset = 1'b0; #3;
    check("t6_boot_fv", fetch_valid, 1'b0);
    next_cycle(); #3;
    check("t6_run_fv", fetch_valid, 1'b1);
    next_cycle(); #3;
    check("t6_run_pc", pc, 32'h4);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
